// File: rtl/udp_tx_meta_prepender.sv
`default_nettype none
// udp_tx_meta_prepender: prepends SRC_IP/DST_IP/LEN/SRC_PORT/DST_PORT words to a UDP
// payload stream and flags descriptor/payload length mismatches.  Rev 1.0
module udp_tx_meta_prepender #(
   parameter int DATA_WIDTH  = 32,
   parameter int MAX_PAYLOAD = 1472
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [31:0]               desc_src_ip,
   input  logic [31:0]               desc_dst_ip,
   input  logic [15:0]               desc_src_port,
   input  logic [15:0]               desc_dst_port,
   input  logic [15:0]               desc_len,
   input  logic                      desc_valid,
   output logic                      desc_ready,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      s_axis_tlast,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic                      busy,
   output logic                      len_err,
   output logic [15:0]               len_err_cnt
);
   localparam logic [15:0] c_MAX_LEN = 16'(MAX_PAYLOAD);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_META    = 2'd1,
      S_PAYLOAD = 2'd2
   } state_t;

   state_t                    state_q;
   logic [31:0]               src_ip_q;
   logic [31:0]               dst_ip_q;
   logic [15:0]               len_q;
   logic [15:0]               src_port_q;
   logic [15:0]               dst_port_q;
   logic [2:0]                idx_q;
   logic [16:0]               byte_cnt_q;
   logic [DATA_WIDTH-1:0]     tdata_q;
   logic [DATA_WIDTH/8-1:0]   tkeep_q;
   logic                      tvalid_q;
   logic                      tlast_q;
   logic                      len_err_q;
   logic [15:0]               err_cnt_q;
   logic [15:0]               err_cnt_d;

   logic                      load_en;
   logic                      beat_hs;
   logic                      desc_bad;
   logic [2:0]                keep_cnt;
   logic [16:0]               byte_total;
   logic [31:0]               meta_word;

   assign load_en    = !tvalid_q || m_axis_tready;
   assign beat_hs    = s_axis_tvalid && s_axis_tready;
   assign desc_bad   = (desc_len == 16'd0) || (desc_len > c_MAX_LEN);
   assign keep_cnt   = {2'b00, s_axis_tkeep[0]} + {2'b00, s_axis_tkeep[1]}
                     + {2'b00, s_axis_tkeep[2]} + {2'b00, s_axis_tkeep[3]};
   assign byte_total = byte_cnt_q + {14'd0, keep_cnt};
   assign err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;

   always_comb begin
      meta_word = src_ip_q;
      case (idx_q)
         3'd1:    meta_word = dst_ip_q;
         3'd2:    meta_word = {16'h0000, len_q};
         3'd3:    meta_word = {16'h0000, src_port_q};
         3'd4:    meta_word = {16'h0000, dst_port_q};
         default: meta_word = src_ip_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         src_ip_q   <= '0;
         dst_ip_q   <= '0;
         len_q      <= '0;
         src_port_q <= '0;
         dst_port_q <= '0;
         idx_q      <= '0;
         byte_cnt_q <= '0;
         tdata_q    <= '0;
         tkeep_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         len_err_q  <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         len_err_q <= 1'b0;
         if (load_en) tvalid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (desc_valid) begin
                  src_ip_q   <= desc_src_ip;
                  dst_ip_q   <= desc_dst_ip;
                  len_q      <= desc_len;
                  src_port_q <= desc_src_port;
                  dst_port_q <= desc_dst_port;
                  if (desc_bad) begin
                     len_err_q <= 1'b1;
                     err_cnt_q <= err_cnt_d;
                  end else begin
                     byte_cnt_q <= '0;
                     state_q    <= S_META;
                     // Word 0 goes straight out unless a previous tlast word is still held.
                     if (load_en) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= desc_src_ip;
                        tkeep_q  <= '1;
                        tlast_q  <= 1'b0;
                        idx_q    <= 3'd1;
                     end else begin
                        idx_q    <= 3'd0;
                     end
                  end
               end
            end
            S_META: begin
               if (load_en) begin
                  tvalid_q <= 1'b1;
                  tdata_q  <= meta_word;
                  tkeep_q  <= '1;
                  tlast_q  <= 1'b0;
                  idx_q    <= idx_q + 3'd1;
                  if (idx_q == 3'd4) state_q <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (beat_hs) begin
                  tvalid_q   <= 1'b1;
                  tdata_q    <= s_axis_tdata;
                  tkeep_q    <= s_axis_tkeep;
                  tlast_q    <= s_axis_tlast;
                  byte_cnt_q <= byte_total;
                  if (s_axis_tlast) begin
                     state_q <= S_IDLE;
                     if (byte_total != {1'b0, len_q}) begin
                        len_err_q <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                     end
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign desc_ready    = (state_q == S_IDLE);
   assign s_axis_tready = (state_q == S_PAYLOAD) && load_en;
   assign busy          = (state_q != S_IDLE);
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tkeep  = tkeep_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign len_err       = len_err_q;
   assign len_err_cnt   = err_cnt_q;

endmodule
`default_nettype wire
